mul_unit_seq: RTL and testbench
===============================

Name: mul_unit_seq

Overview:
- Parametrised sequential RV32/RV64 M-extension multiplier. It is the successor to the single-bit shift-add multiplier.
- Width is generic; bits retired per cycle are configurable.
- Adds an abort input, a busy flag, and an optional result cache for back-to-back MUL/MULH* pairs.
- Sits in the execute stage beside the divider. Uses the `MUL_OP_* encodings from riscv_defines.svh.

Parameters:
- XLEN, 32, operand/product width.
- BITS_PER_CYCLE, 1, multiplier bits consumed per CALC cycle. Power of two; must divide XLEN; elaboration error otherwise.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- factor1  input  XLEN  operand rs1
- factor2  input  XLEN  operand rs2
- MULop  input  `MUL_OP_WIDTH  MUL / MULH / MULSU / MULU select
- valid  input  1  request, held until ready
- kill  input  1  abort in-flight op (pipeline flush)
- product  output  XLEN  result, held until next accept
- ready  output  1  one-cycle completion pulse
- busy  output  1  op in flight

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on reset. Reset wins over all other inputs.
- Reset values: product=0, ready=0, busy=0, state=IDLE, cache invalid.
- Signedness:
  - f1 is signed for MULH and MULSU.
  - f2 is signed for MULH only.
  - MUL and MULU are treated as fully unsigned.
- Magnitudes: abs = negate if signed and MSB set. -2^(XLEN-1) maps to unsigned 2^(XLEN-1) with no overflow.
- Sign fix: neg = (f1 signed & f1 MSB) XOR (f2 signed & f2 MSB).
- Result selection: product = acc[XLEN-1:0] for MUL, acc[2XLEN-1:XLEN] otherwise.
- N = XLEN/BITS_PER_CYCLE.
- States:
  - IDLE: busy=0. Accept when valid=1 and ready=0; valid is ignored in the ready cycle. On accept, latch abs operands, op and neg; clear the 2XLEN accumulator and counter; go to CALC (or DONE on a cache hit).
  - CALC: busy=1. Each cycle, acc += (abs1 * abs2[k*BPC +: BPC]) << (k*BPC) for k = counter, then counter++. After N cycles go to FIX.
  - FIX: busy=1. If neg, acc <= two's complement of acc. Go to DONE.
  - DONE: update product from acc/op, set ready=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: accept edge T gives ready high in cycle T+N+2. Examples: 34 for XLEN=32/BPC=1; 10 for BPC=4.
- product changes only on the DONE transition. It is stable from the ready pulse until the next completion.
- kill, when not in IDLE: next cycle state=IDLE, busy=0, no ready pulse, product unchanged, cache invalidated. kill in IDLE together with valid blocks the accept.
- Simultaneous kill and DONE: kill wins; no ready pulse.
- Reset mid-operation: same as kill, but product is also cleared to 0.
- Operands and MULop may change after accept without affecting the result.

Optional Feature:
- Macro: MUL_RESULT_CACHE_EN.
- When defined:
  - Store the last completed 2XLEN signed-corrected result, the raw factor1/factor2, and its signedness mode (MULH, MULSU, or unsigned).
  - Hit condition on accept: factors equal AND (mode equal OR new op is MUL).
  - On a hit, skip CALC/FIX and go straight to DONE; ready in cycle T+1.
  - Cache is invalidated by reset or kill.
- When undefined: no cache storage; every op takes N+2 cycles.

Test Plan:
- 0xFFFFFFFF x 0xFFFFFFFF, XLEN=32 -> MUL 0x00000001, MULU 0xFFFFFFFE, MULH 0x00000000, MULSU 0xFFFFFFFF. Each ready at T+34 with the cache off.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. Repeat with BITS_PER_CYCLE=4 -> same value, ready at T+10.
- Assert kill at CALC cycle 5 of an op -> no ready pulse, busy=0 next cycle. A following MUL 3 x 5 returns 0x0000000F.
- Assert reset mid-CALC -> ready=0, busy=0, product=0 the next cycle. The next op completes normally.
- Hold valid high across completion -> no accept in the ready cycle; second op accepted the cycle after; exactly one ready per op.
- With MUL_RESULT_CACHE_EN:
  - MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB.
  - Then MULU with the same operands -> 0x00000006, ready at T+1 (hit).
  - Then MULH with the same operands -> 0xFFFFFFFF at T+34 (miss, mode differs).

Source files
------------

// File: rtl/mul_unit_seq.sv
// mul_unit_seq: sequential RV32/RV64 M-extension multiplier, BITS_PER_CYCLE multiplier bits per CALC cycle
//   clk/reset (sync, active-high); factor1/factor2 rs1/rs2; MULop MUL/MULH/MULSU/MULU; valid request held until ready;
//   kill aborts the op in flight; product result held until next completion; ready one-cycle done pulse; busy op in flight.
//   MUL_RESULT_CACHE_EN: keep the last full product so a matching back-to-back MUL/MULH* pair completes in one cycle.
`ifndef MUL_OP_WIDTH
`define MUL_OP_WIDTH 2
`endif
`ifndef MUL_OP_MUL
`define MUL_OP_MUL 2'b00
`endif
`ifndef MUL_OP_MULH
`define MUL_OP_MULH 2'b01
`endif
`ifndef MUL_OP_MULSU
`define MUL_OP_MULSU 2'b10
`endif
`ifndef MUL_OP_MULU
`define MUL_OP_MULU 2'b11
`endif
module mul_unit_seq #(
  parameter int XLEN = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XLEN-1:0]          factor1,
  input  logic [XLEN-1:0]          factor2,
  input  logic [`MUL_OP_WIDTH-1:0] MULop,
  input  logic                     valid,
  input  logic                     kill,
  output logic [XLEN-1:0]          product,
  output logic                     ready,
  output logic                     busy
);
  localparam int N = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int W2 = 2 * XLEN;
  if (BITS_PER_CYCLE < 1 || XLEN % BITS_PER_CYCLE != 0 || (BITS_PER_CYCLE & (BITS_PER_CYCLE - 1)) != 0) begin : g_bad_cfg
    $error("BITS_PER_CYCLE must be a power of two that divides XLEN");
  end
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t r_state, w_next;
  logic [XLEN-1:0] r_abs1, r_abs2;
  logic [W2-1:0] r_acc, w_part, w_hit_acc;
  logic [CW-1:0] r_cnt;
  logic [31:0] w_sh;
  logic [BITS_PER_CYCLE-1:0] w_slice;
  logic r_neg, r_lo;
  logic w_s1, w_s2, w_n1, w_n2, w_accept, w_hit;
  assign w_s2 = MULop == `MUL_OP_MULH;
  assign w_s1 = w_s2 || MULop == `MUL_OP_MULSU;
  assign w_n1 = w_s1 && factor1[XLEN-1];
  assign w_n2 = w_s2 && factor2[XLEN-1];
  // valid is ignored while ready is high so a held request is not taken twice
  assign w_accept = r_state == IDLE && valid && !ready && !kill;
  assign w_sh = 32'(r_cnt) * 32'(BITS_PER_CYCLE);
  assign w_slice = BITS_PER_CYCLE'(r_abs2 >> w_sh);
  assign w_part = (W2'(r_abs1) * W2'(w_slice)) << w_sh;
  assign busy = r_state == CALC || r_state == FIX;
`ifdef MUL_RESULT_CACHE_EN
  logic r_c_v;
  logic [XLEN-1:0] r_c_f1, r_c_f2, r_f1, r_f2;
  logic [1:0] r_c_mode, r_mode;
  logic [W2-1:0] r_c_acc;
  // the low half is identical for every signedness, so MUL may reuse any cached mode
  assign w_hit = r_c_v && factor1 == r_c_f1 && factor2 == r_c_f2 && ({w_s2, w_s1} == r_c_mode || MULop == `MUL_OP_MUL);
  assign w_hit_acc = r_c_acc;
  always_ff @(posedge clk) begin
    if (reset || kill) r_c_v <= 1'b0;
    else begin
      if (w_accept) begin
        r_f1 <= factor1;
        r_f2 <= factor2;
        r_mode <= {w_s2, w_s1};
      end
      if (r_state == DONE) begin
        r_c_v <= 1'b1;
        r_c_f1 <= r_f1;
        r_c_f2 <= r_f2;
        r_c_mode <= r_mode;
        r_c_acc <= r_acc;
      end
    end
  end
`else
  assign w_hit = 1'b0;
  assign w_hit_acc = '0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_accept ? (w_hit ? DONE : CALC) : IDLE;
      CALC: w_next = r_cnt == CW'(N - 1) ? FIX : CALC;
      FIX: w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (kill) w_next = IDLE;
  end
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      product <= '0;
      ready <= 1'b0;
    end else begin
      ready <= r_state == DONE && !kill;
      if (r_state == DONE && !kill) product <= r_lo ? r_acc[XLEN-1:0] : r_acc[W2-1:XLEN];
      if (w_accept) begin
        r_abs1 <= w_n1 ? -factor1 : factor1;
        r_abs2 <= w_n2 ? -factor2 : factor2;
        r_neg <= w_n1 ^ w_n2;
        r_lo <= MULop == `MUL_OP_MUL;
        r_acc <= w_hit ? w_hit_acc : '0;
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        r_acc <= r_acc + w_part;
        r_cnt <= r_cnt + CW'(1);
      end else if (r_state == FIX && r_neg) r_acc <= -r_acc;
    end
  end
endmodule

// File: tb/tb_mul_unit_seq.sv
// tb_mul_unit_seq: scoreboard bench for mul_unit_seq against an arithmetic reference model
module tb_mul_unit_seq;
  localparam int XLEN = 32;
  localparam int BPC = 1;
  localparam int LAT = XLEN / BPC + 2;
  localparam logic [1:0] OP_MUL = 2'd0, OP_MULH = 2'd1, OP_MULSU = 2'd2, OP_MULU = 2'd3;
`ifdef MUL_RESULT_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif
  typedef struct {logic [31:0] val; int due;} exp_t;
  logic clk = 1'b0, reset = 1'b1, valid = 1'b0, kill = 1'b0;
  logic [31:0] factor1 = '0, factor2 = '0;
  logic [1:0] MULop = '0;
  logic [31:0] product;
  logic ready, busy;
  int checks = 0, failures = 0, cyc = 0, last_due = 0;
  exp_t q[$];
  exp_t m_e;
  logic [31:0] held = '0;
  logic c_v = 1'b0;
  logic [31:0] c_a = '0, c_b = '0;
  logic [1:0] c_m = '0;
  mul_unit_seq #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .reset(reset), .factor1(factor1), .factor2(factor2), .MULop(MULop),
    .valid(valid), .kill(kill), .product(product), .ready(ready), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] ref_mul(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic s1, s2;
    logic [65:0] x, y, p;
    s1 = op == OP_MULH || op == OP_MULSU;
    s2 = op == OP_MULH;
    x = {{34{s1 & a[31]}}, a};
    y = {{34{s2 & b[31]}}, b};
    p = x * y;
    return op == OP_MUL ? p[31:0] : p[63:32];
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_ready actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          m_e = q.pop_front();
          chk("product", product, m_e.val);
          chk("latency", cyc, m_e.due);
          held = m_e.val;
        end
      end else chk("product_hold", product, held);
    end
  end
  task automatic book(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [1:0] m;
    bit hit;
    m = {op == OP_MULH, op == OP_MULH || op == OP_MULSU};
    hit = CACHE_ON && c_v && a == c_a && b == c_b && (m == c_m || op == OP_MUL);
    last_due = cyc + (hit ? 1 : LAT);
    q.push_back('{ref_mul(op, a, b), last_due});
    chk("busy_after_accept", busy, !hit);
    c_v = 1'b1;
    c_a = a;
    c_b = b;
    c_m = m;
  endtask
  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b, bit keep);
    factor1 = a;
    factor2 = b;
    MULop = op;
    valid = 1'b1;
    @(posedge clk);
    #1;
    book(op, a, b);
    if (!keep) begin
      valid = 1'b0;
      factor1 = $urandom;
      factor2 = $urandom;
      MULop = 2'($urandom);
    end
  endtask
  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 4 * LAT) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL completion_timeout pending=%0d expected=0", q.size());
      q.delete();
    end
  endtask
  task automatic run(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    issue(op, a, b, 1'b0);
    wait_done();
  endtask
  function automatic logic [31:0] pick(logic [31:0] prev);
    int r = $urandom_range(0, 7);
    return r == 0 ? 32'h8000_0000 : r == 1 ? 32'hFFFF_FFFF : r == 2 ? 32'h0 : r == 3 ? 32'h1 : r == 4 ? prev : $urandom;
  endfunction
  initial begin
    #500_000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] la, lb;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_product", product, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(OP_MULSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(OP_MULH, 32'h8000_0000, 32'h8000_0000);
    run(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    run(OP_MULU, 32'd7, 32'hFFFF_FFFD);
    run(OP_MULH, 32'd7, 32'hFFFF_FFFD);
    issue(OP_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    q.delete();
    c_v = 1'b0;
    chk("kill_busy", busy, 0);
    chk("kill_ready", ready, 0);
    chk("kill_product", product, held);
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
    end
    run(OP_MUL, 32'd3, 32'd5);
    issue(OP_MULU, 32'h0001_2345, 32'h0000_6789, 1'b0);
    repeat (LAT - 1) begin
      @(posedge clk);
      #1;
    end
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    q.delete();
    c_v = 1'b0;
    chk("kill_done_ready", ready, 0);
    chk("kill_done_busy", busy, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    issue(OP_MULSU, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    held = '0;
    q.delete();
    c_v = 1'b0;
    chk("midreset_ready", ready, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_product", product, 0);
    reset = 1'b0;
    run(OP_MULH, 32'hFFFF_FFF9, 32'd6);
    issue(OP_MULU, 32'hCAFE_0001, 32'h0000_0003, 1'b1);
    factor1 = 32'h7FFF_FFFF;
    factor2 = 32'h8000_0001;
    MULop = OP_MULSU;
    while (cyc < last_due + 2) begin
      @(posedge clk);
      #1;
    end
    book(OP_MULSU, 32'h7FFF_FFFF, 32'h8000_0001);
    valid = 1'b0;
    wait_done();
    la = 32'h5;
    lb = 32'h9;
    for (int i = 0; i < 60; i++) begin
      la = pick(la);
      lb = pick(lb);
      run(2'($urandom_range(0, 3)), la, lb);
    end
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
